rsa_operand_fetch: RTL and testbench

//   Sequences the 256x32 operand SRAM (1-cycle sync read, address registered on en) for the RSA core.
//   On start, reads message (64 words), exponent key E/D (64) and modulus N (64) in that order.

---
 rtl/rsa_operand_fetch.sv | 177 +++++++++++++++++
 tb/tb_rsa_operand_fetch.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_operand_fetch.sv
// rsa_operand_fetch
//   Walks the operand SRAM for one modular exponentiation: 64 message words,
//   64 key (E/D) words, then 64 modulus words, and presents each word on a
//   valid/ready stream tagged with its operand select and word index.
//   The SRAM has a 1-cycle synchronous read and captures its address on
//   sram_en, so while the consumer stalls we simply stop enabling the SRAM.
//   Its output then stays on the last word, and no skid buffer is needed.
//
//   Optional feature (macro RSA_FETCH_PERF_EN):
//     adds the stall_cnt output, a saturating count of cycles in which a beat
//     was offered but not accepted. The count is cleared on start and holds
//     after done. When the macro is undefined the port and the counter are
//     both absent.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for start; issue pointer parked at 0
//   S_FETCH | issuing SRAM reads and streaming beats
//   S_DONE  | last beat accepted; done pulses for this single cycle
module rsa_operand_fetch #(
  parameter int DW       = 32,
  parameter int AW       = 8,
  parameter int WORDS    = 64,
  parameter int MSG_BASE = 0,
  parameter int KEY_BASE = 64,
  parameter int MOD_BASE = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          sram_en,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_sel,
  output logic [5:0]    out_idx
`ifdef RSA_FETCH_PERF_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [5:0] IDX_LAST = 6'(WORDS - 1);

  state_t        state;
  // The issue pointer is kept as {segment, index}. Segment 3 means that all
  // 3*WORDS reads have been issued.
  logic [1:0]    seg;
  logic [5:0]    idx;
  logic          pending;
  logic          issue_end;
  logic          accept;
  logic          launch;
  logic [AW-1:0] base_addr;

  assign issue_end = (seg == 2'd3);
  assign accept    = pending & out_ready;
  // A new read may launch only when the output register is empty or is being
  // drained this cycle. Launching during a stall would overwrite the word the
  // consumer has not taken yet. abort suppresses the final read.
  assign launch    = (state == S_FETCH) & ~issue_end & (~pending | out_ready) & ~abort;

  assign sram_en   = launch;
  assign out_valid = pending;
  assign out_data  = sram_data;

  // Map the operand segment to its SRAM block base and add the word index.
  always_comb begin
    base_addr = '0;
    case (seg)
      2'd0:    base_addr = AW'(MSG_BASE);
      2'd1:    base_addr = AW'(KEY_BASE);
      2'd2:    base_addr = AW'(MOD_BASE);
      default: base_addr = '0;
    endcase
    sram_addr = base_addr + AW'(idx);
  end

  // Sequencer: controls the issue pointer, the pending beat, and the
  // registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      seg     <= 2'd0;
      idx     <= 6'd0;
      pending <= 1'b0;
      out_sel <= 2'd0;
      out_idx <= 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          seg     <= 2'd0;
          idx     <= 6'd0;
          pending <= 1'b0;
          if (start && !abort) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end

        S_FETCH: begin
          if (abort) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            pending <= 1'b0;
            seg     <= 2'd0;
            idx     <= 6'd0;
          end else begin
            if (launch) begin
              pending <= 1'b1;
              out_sel <= seg;
              out_idx <= idx;
              if (idx == IDX_LAST) begin
                idx <= 6'd0;
                seg <= seg + 2'd1;
              end else begin
                idx <= idx + 6'd1;
              end
            end else if (accept) begin
              pending <= 1'b0;
            end
            // Finish in the cycle in which the final beat is taken. done then
            // appears in the cycle right after the last handshake.
            if (issue_end && (!pending || accept)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          seg   <= 2'd0;
          idx   <= 6'd0;
        end

        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          pending <= 1'b0;
        end
      endcase
    end
  end

`ifdef RSA_FETCH_PERF_EN
  // Count the cycles in which the consumer back-pressures an offered beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (state == S_IDLE && start && !abort) begin
      stall_cnt <= 16'd0;
    end else if (pending && !out_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rsa_operand_fetch.sv
// Testbench for rsa_operand_fetch: SRAM model preloaded with A5000000+i,
// per-cycle recording of DUT outputs, and a reference model that derives each
// expected beat from the operand order (message, key, modulus).
module tb_rsa_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        sram_en;
  logic [7:0]  sram_addr;
  logic [31:0] sram_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic [5:0]  out_idx;
`ifdef RSA_FETCH_PERF_EN
  logic [15:0] stall_cnt;
`endif

  rsa_operand_fetch dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .busy(busy),
    .done(done),
    .sram_en(sram_en),
    .sram_addr(sram_addr),
    .sram_data(sram_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sel(out_sel),
    .out_idx(out_idx)
`ifdef RSA_FETCH_PERF_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: 1-cycle synchronous read; the address is captured when en is high.
  logic [31:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 + 32'(i);
    sram_data = 32'h0;
  end
  always @(posedge clk) if (sram_en) sram_data <= ram[sram_addr];

  localparam int MAXC = 1024;
  bit          r_valid [MAXC];
  bit          r_ready [MAXC];
  bit          r_en    [MAXC];
  bit          r_busy  [MAXC];
  bit          r_done  [MAXC];
  logic [31:0] r_data  [MAXC];
  logic [1:0]  r_sel   [MAXC];
  logic [5:0]  r_idx   [MAXC];
  logic [7:0]  r_addr  [MAXC];
  logic [31:0] b_data  [256];
  logic [1:0]  b_sel   [256];
  logic [5:0]  b_idx   [256];
  int          b_cyc   [256];
  int nbeats, ndone, done_cyc, ncyc_run, abort_cyc, rst_cyc;
  int vectors, errors;

  // Reference model: beat k is word k%64 of operand k/64, and the operands are
  // laid out at the block bases 0, 64 and 128.
  function automatic logic [39:0] exp_beat(input int k);
    int sel, idx, base;
    sel = k / 64;
    idx = k % 64;
    case (sel)
      0:       base = 0;
      1:       base = 64;
      default: base = 128;
    endcase
    return {2'(sel), 6'(idx), 32'hA500_0000 + 32'(base + idx)};
  endfunction

  // Stimulus/recording engine. Cycle 0 is the cycle in which start is high.
  // ready_mode: 0 = high, 1 = toggle, 2 = random.
  task automatic run(input int ncyc, input int ready_mode, input int stall_beat,
                     input int stall_len, input int abort_beat, input int start_beat,
                     input int rst_beat);
    int nb, srem;
    bit restarted;
    nb = 0; srem = stall_len; restarted = 0;
    nbeats = 0; ndone = 0; done_cyc = -1; abort_cyc = -1; rst_cyc = -1; ncyc_run = 0;
    for (int c = 0; c < ncyc && c < MAXC; c++) begin
      start = (c == 0);
      abort = 1'b0;
      case (ready_mode)
        1:       out_ready = (c % 2 == 1);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      if (nb == stall_beat && srem > 0) begin out_ready = 1'b0; srem--; end
      if (c > 0 && nb == start_beat && !restarted) begin start = 1'b1; restarted = 1; end
      if (nb == abort_beat && abort_cyc < 0) begin abort = 1'b1; out_ready = 1'b0; abort_cyc = c; end
      if (nb == rst_beat && rst_cyc < 0) begin rst_n = 1'b0; rst_cyc = c; end
      @(negedge clk);
      r_valid[c] = out_valid; r_ready[c] = out_ready; r_en[c] = sram_en;
      r_busy[c] = busy; r_done[c] = done; r_data[c] = out_data;
      r_sel[c] = out_sel; r_idx[c] = out_idx; r_addr[c] = sram_addr;
      if (out_valid && out_ready && nbeats < 256) begin
        b_data[nbeats] = out_data; b_sel[nbeats] = out_sel;
        b_idx[nbeats] = out_idx; b_cyc[nbeats] = c;
        nbeats++; nb++;
      end
      if (done) begin ndone++; done_cyc = c; end
      ncyc_run = c + 1;
      @(posedge clk); #1;
      if (rst_cyc >= 0) break;
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      if (abort_cyc >= 0 && c >= abort_cyc + 6) break;
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, sram_en, sram_addr, out_valid, out_sel, out_idx} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b en=%b addr=%h valid=%b sel=%0d idx=%0d, want all 0",
               busy, done, sram_en, sram_addr, out_valid, out_sel, out_idx);
    end
`ifdef RSA_FETCH_PERF_EN
    vectors++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    logic [39:0] e;
    run(400, 0, -1, 0, -1, -1, -1);
    vectors++;
    if (nbeats !== 192) begin errors++; $display("FAIL stream_count: got %0d want 192", nbeats); end
    for (int k = 0; k < nbeats; k++) begin
      e = exp_beat(k);
      vectors++;
      if ({b_sel[k], b_idx[k], b_data[k]} !== e || b_cyc[k] !== k + 2) begin
        errors++;
        $display("FAIL stream_beat%0d: got sel=%0d idx=%0d data=%h cyc=%0d, want %h cyc=%0d",
                 k, b_sel[k], b_idx[k], b_data[k], b_cyc[k], e, k + 2);
      end
    end
    for (int c = 0; c < ncyc_run; c++) begin
      vectors++;
      if (r_en[c] !== (c >= 1 && c <= 192) || (r_en[c] && r_addr[c] !== 8'(c - 1))) begin
        errors++;
        $display("FAIL stream_en_c%0d: got en=%b addr=%h, want en=%b addr=%h",
                 c, r_en[c], r_addr[c], (c >= 1 && c <= 192), 8'(c - 1));
      end
    end
    vectors++;
    if (ndone !== 1 || done_cyc !== 194) begin
      errors++; $display("FAIL stream_done: got count=%0d cyc=%0d, want 1 at 194", ndone, done_cyc);
    end
  endtask

  task automatic test_stall();
    logic [39:0] e;
    int stalls;
    stalls = 0;
    run(400, 0, 10, 5, -1, -1, -1);
    vectors++;
    if (nbeats !== 192) begin errors++; $display("FAIL stall_count: got %0d want 192", nbeats); end
    for (int k = 0; k < nbeats; k++) begin
      e = exp_beat(k);
      vectors++;
      if ({b_sel[k], b_idx[k], b_data[k]} !== e) begin
        errors++; $display("FAIL stall_beat%0d: got %h want %h", k, {b_sel[k], b_idx[k], b_data[k]}, e);
      end
    end
    for (int c = 0; c + 1 < ncyc_run; c++) begin
      if (r_valid[c] && !r_ready[c]) begin
        stalls++;
        vectors++;
        if (r_en[c] !== 1'b0 || r_data[c] !== 32'hA500_000A || r_sel[c] !== 2'd0 || r_idx[c] !== 6'd10
            || r_valid[c+1] !== 1'b1 || r_data[c+1] !== r_data[c]) begin
          errors++;
          $display("FAIL stall_hold_c%0d: got en=%b data=%h sel=%0d idx=%0d next=%h, want en=0 A500000A 0 10 held",
                   c, r_en[c], r_data[c], r_sel[c], r_idx[c], r_data[c+1]);
        end
      end
    end
    vectors++;
    if (stalls !== 5 || ndone !== 1 || done_cyc !== 199) begin
      errors++; $display("FAIL stall_done: got stalls=%0d done=%0d at %0d, want 5,1,199", stalls, ndone, done_cyc);
    end
`ifdef RSA_FETCH_PERF_EN
    vectors++;
    if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt); end
`endif
  endtask

  task automatic test_abort();
    run(400, 0, -1, 0, 100, -1, -1);
    vectors++;
    if (nbeats !== 100 || ndone !== 0 || abort_cyc !== 102) begin
      errors++; $display("FAIL abort_summary: got beats=%0d done=%0d acyc=%0d, want 100,0,102", nbeats, ndone, abort_cyc);
    end
    for (int c = abort_cyc + 1; c < ncyc_run; c++) begin
      vectors++;
      if (r_busy[c] !== 1'b0 || r_valid[c] !== 1'b0 || r_en[c] !== 1'b0 || r_done[c] !== 1'b0) begin
        errors++;
        $display("FAIL abort_after_c%0d: got busy=%b valid=%b en=%b done=%b, want 0",
                 c, r_busy[c], r_valid[c], r_en[c], r_done[c]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [39:0] e;
    run(400, 0, -1, 0, -1, 50, -1);
    vectors++;
    if (nbeats !== 192 || ndone !== 1 || done_cyc !== 194) begin
      errors++; $display("FAIL restart_summary: got beats=%0d done=%0d at %0d, want 192,1,194", nbeats, ndone, done_cyc);
    end
    for (int k = 0; k < nbeats; k++) begin
      e = exp_beat(k);
      vectors++;
      if ({b_sel[k], b_idx[k], b_data[k]} !== e) begin
        errors++; $display("FAIL restart_beat%0d: got %h want %h", k, {b_sel[k], b_idx[k], b_data[k]}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    run(400, 0, -1, 0, -1, -1, 30);
    vectors++;
    if (rst_cyc !== 32 || {r_busy[rst_cyc], r_done[rst_cyc], r_en[rst_cyc], r_addr[rst_cyc],
                           r_valid[rst_cyc], r_sel[rst_cyc], r_idx[rst_cyc]} !== 19'd0) begin
      errors++;
      $display("FAIL midreset_outputs: cyc=%0d busy=%b done=%b en=%b addr=%h valid=%b sel=%0d idx=%0d, want cyc 32 all 0",
               rst_cyc, r_busy[rst_cyc], r_done[rst_cyc], r_en[rst_cyc], r_addr[rst_cyc],
               r_valid[rst_cyc], r_sel[rst_cyc], r_idx[rst_cyc]);
    end
    run(400, 0, -1, 0, -1, -1, -1);
    vectors++;
    if (nbeats !== 192 || b_data[0] !== 32'hA500_0000 || b_cyc[0] !== 2 || done_cyc !== 194) begin
      errors++;
      $display("FAIL midreset_restart: got beats=%0d data0=%h cyc0=%0d done=%0d, want 192 A5000000 2 194",
               nbeats, b_data[0], b_cyc[0], done_cyc);
    end
  endtask

  task automatic test_ready_pattern(input int mode);
    logic [39:0] e;
    int holds;
    holds = 0;
    run(MAXC, mode, -1, 0, -1, -1, -1);
    vectors++;
    if (nbeats !== 192 || ndone !== 1) begin
      errors++; $display("FAIL pattern%0d_count: got beats=%0d done=%0d, want 192,1", mode, nbeats, ndone);
    end
    for (int k = 0; k < nbeats; k++) begin
      e = exp_beat(k);
      vectors++;
      if ({b_sel[k], b_idx[k], b_data[k]} !== e) begin
        errors++; $display("FAIL pattern%0d_beat%0d: got %h want %h", mode, k, {b_sel[k], b_idx[k], b_data[k]}, e);
      end
    end
    for (int c = 0; c + 1 < ncyc_run; c++) begin
      if (r_valid[c] && !r_ready[c]) begin
        holds++;
        vectors++;
        if (r_en[c] !== 1'b0 || r_valid[c+1] !== 1'b1 ||
            {r_sel[c+1], r_idx[c+1], r_data[c+1]} !== {r_sel[c], r_idx[c], r_data[c]}) begin
          errors++;
          $display("FAIL pattern%0d_hold_c%0d: got en=%b next=%h, want en=0 next=%h", mode, c, r_en[c],
                   {r_sel[c+1], r_idx[c+1], r_data[c+1]}, {r_sel[c], r_idx[c], r_data[c]});
        end
      end
    end
    if (nbeats > 0) begin
      vectors++;
      if (done_cyc !== b_cyc[nbeats-1] + 1) begin
        errors++; $display("FAIL pattern%0d_done_cyc: got %0d want %0d", mode, done_cyc, b_cyc[nbeats-1] + 1);
      end
    end
`ifdef RSA_FETCH_PERF_EN
    vectors++;
    if (stall_cnt !== 16'(holds)) begin
      errors++; $display("FAIL pattern%0d_stall_cnt: got %0d want %0d", mode, stall_cnt, holds);
    end
`endif
  endtask

  task automatic test_start_abort();
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || sram_en !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL start_abort_c%0d: got busy=%b en=%b valid=%b, want 0", c, busy, sram_en, out_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vectors = 0; errors = 0;
    test_reset();
    test_stream();
    test_stall();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    test_ready_pattern(1);
    test_ready_pattern(2);
    test_ready_pattern(2);
    test_start_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
